// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divide sequencer.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration; purely combinational so it can be chained.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;

    // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign rem_sub = rem_sh[WIDTH-1:0] - divisor;

    always_comb begin
        rem_next = rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (rem_sh >= {1'b0, divisor}) begin
            rem_next = rem_sub;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: one quotient bit per clock with signed correction and divide-by-zero handling.
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t             state, state_d;
    logic               sign_a, sign_a_d;
    logic               sign_b, sign_b_d;
    logic               zero, zero_d;
    logic [WIDTH-1:0]   rem_r, rem_d;
    logic [WIDTH-1:0]   quo_r, quo_d;
    logic [WIDTH-1:0]   div_r, div_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               busy_d, done_d;
    logic [WIDTH-1:0]   quotient_d, remainder_d;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign neg_a = a[WIDTH-1] & is_signed;
    assign neg_b = b[WIDTH-1] & is_signed;
    assign abs_a = neg_a ? -a : a;
    assign abs_b = neg_b ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_r),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            zero      <= 1'b0;
            rem_r     <= '0;
            quo_r     <= '0;
            div_r     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state     <= state_d;
            sign_a    <= sign_a_d;
            sign_b    <= sign_b_d;
            zero      <= zero_d;
            rem_r     <= rem_d;
            quo_r     <= quo_d;
            div_r     <= div_d;
            cnt       <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            quotient  <= quotient_d;
            remainder <= remainder_d;
        end
    end

    // Next-state logic; flush aborts anything in flight.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (start && !flush) state_d = (b == '0) ? FIX : CALC;
            CALC: if (cnt == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush && state != IDLE) state_d = IDLE;
    end

    // Datapath and output next values.
    always_comb begin
        sign_a_d    = sign_a;
        sign_b_d    = sign_b;
        zero_d      = zero;
        rem_d       = rem_r;
        quo_d       = quo_r;
        div_d       = div_r;
        cnt_d       = cnt;
        quotient_d  = quotient;
        remainder_d = remainder;
        busy_d      = (state_d == CALC) || (state_d == FIX);
        done_d      = (state_d == DONE);
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    sign_a_d = neg_a;
                    sign_b_d = neg_b;
                    zero_d   = (b == '0);
                    // On divide-by-zero the raw dividend rides in quo_r to become the remainder.
                    quo_d    = (b == '0) ? a : abs_a;
                    div_d    = abs_b;
                    rem_d    = '0;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt + CNT_W'(1);
            end
            FIX: begin
                if (state_d == DONE) begin
                    if (zero) begin
                        quotient_d  = DIV_ZERO_QUO[WIDTH-1:0];
                        remainder_d = quo_r;
                    end else begin
                        quotient_d  = (sign_a ^ sign_b) ? -quo_r : quo_r;
                        remainder_d = sign_a ? -rem_r : rem_r;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl.
module tb_div_ctrl;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int errors = 0;
    int checks = 0;

    div_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request, then waits for done; lat = cycles after the start edge where done is seen.
    task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int bcnt);
        @(negedge clk);
        is_signed = s; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        bcnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcnt++;
        end
        q = quotient;
        r = remainder;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; flush = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h, want 0 0 0 0", busy, done, quotient, remainder);
        end
    endtask

    task automatic test_divu_basic();
        logic [31:0] q, r;
        int lat, bc;
        run_op(1'b0, 32'd100, 32'd7, q, r, lat, bc);
        checks++;
        if (q !== 32'd14) begin errors++; $display("FAIL divu_q: got %h want %h", q, 32'd14); end
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL divu_r: got %h want %h", r, 32'd2); end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
        checks++;
        if (bc !== 33) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 33", bc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_in_done: got %b want 0", busy); end
        // start held through the done cycle must be ignored
        start = 1'b1; a = 32'd9; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL start_in_done: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_signed();
        logic [31:0] va [5]  = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] vb [5]  = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1};
        logic        vs [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] eq [5]  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] er [5]  = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] q, r;
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            run_op(vs[i], va[i], vb[i], q, r, lat, bc);
            checks++;
            if (q !== eq[i]) begin errors++; $display("FAIL signed_q[%0d]: got %h want %h", i, q, eq[i]); end
            checks++;
            if (r !== er[i]) begin errors++; $display("FAIL signed_r[%0d]: got %h want %h", i, r, er[i]); end
        end
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, q, r, lat, bc);
        checks++;
        if (q !== 32'd0 || r !== 32'h80000000) begin
            errors++; $display("FAIL divu_big: got q=%h r=%h want q=0 r=80000000", q, r);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] za [3] = '{32'h1234, 32'h1234, 32'hFFFFFFF9};
        logic        zs [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] q, r;
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(zs[i], za[i], 32'd0, q, r, lat, bc);
            checks++;
            if (q !== 32'hFFFFFFFF || r !== za[i]) begin
                errors++; $display("FAIL div0_result[%0d]: got q=%h r=%h want q=ffffffff r=%h", i, q, r, za[i]);
            end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL div0_latency[%0d]: got %0d want 1", i, lat); end
            checks++;
            if (bc !== 1) begin errors++; $display("FAIL div0_busy_cycles[%0d]: got %0d want 1", i, bc); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] q, r;
        int lat, bc;
        int seen;
        // previous op left q=ffffffff r=fffffff9
        @(negedge clk);
        is_signed = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d done cycles want 0", seen); end
        checks++;
        if (quotient !== 32'hFFFFFFFF || remainder !== 32'hFFFFFFF9) begin
            errors++; $display("FAIL flush_hold: got q=%h r=%h want ffffffff fffffff9", quotient, remainder);
        end
        // flush and start together in IDLE: request dropped
        start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_idle: busy got %b want 0", busy); end
        run_op(1'b0, 32'd9, 32'd2, q, r, lat, bc);
        checks++;
        if (q !== 32'd4 || r !== 32'd1) begin
            errors++; $display("FAIL after_flush: got q=%h r=%h want 4 1", q, r);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        is_signed = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            start = (i == 5);
            if (i == 5) begin is_signed = 1'b1; a = 32'd9; b = 32'd2; end
            if (done) begin lat = i; break; end
        end
        start = 1'b0;
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || lat !== 33) begin
            errors++; $display("FAIL start_in_calc: got q=%h r=%h lat=%0d want e 2 33", quotient, remainder, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r;
        int lat, bc;
        int seen;
        @(negedge clk);
        is_signed = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
            errors++; $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h want 0 0 0 0", busy, done, quotient, remainder);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_mid_idle: got %0d active cycles want 0", seen); end
        run_op(1'b0, 32'd50, 32'd5, q, r, lat, bc);
        checks++;
        if (q !== 32'd10 || r !== 32'd0 || lat !== 33) begin
            errors++; $display("FAIL after_reset: got q=%h r=%h lat=%0d want a 0 33", q, r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_flush();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
